airplane_render: RTL and testbench
==================================

Name: airplane_render

Overview:
- Reader/consumer of the airplane position bus (apx, apy). Converts position into pixels: for each VGA scan coordinate, outputs whether the airplane sprite covers that pixel and in which colour.
- Sits between the position logic and the VGA colour mux.
- Samples the position once per frame so the sprite never tears.
- Hit pulses start an invulnerability blink sequence.

Parameters:
- SPR_W, 40, sprite width in pixels (apx is horizontal centre).
- SPR_H, 24, sprite height in pixels (apy is vertical centre).
- BLINK_FRAMES, 96, frames of blinking after a hit.
- BLINK_HALF, 8, frames per visible/invisible half-period.
- PLANE_RGB, 24'hFFD000, body colour {R,G,B}.

Ports:
- game_clk  in  1  system clock (pixel clock domain); all logic on its rising edge.
- reset  in  1  synchronous, active-low reset.
- frame_start  in  1  one-cycle pulse at start of vertical blanking.
- px  in  10  current scan column, 0..799.
- py  in  10  current scan row, 0..524.
- pix_valid  in  1  px/py is inside the active 640x480 area.
- apx  in  10  airplane centre x from position logic, 20..659.
- apy  in  10  airplane centre y from position logic.
- hit  in  1  one-cycle collision pulse.
- pix_on  out  1  sprite covers this pixel (2-cycle latency).
- rgb  out  24  colour when pix_on=1, else 0.
- out_valid  out  1  pix_valid delayed 2 cycles.
- blinking  out  1  high while in BLINK state.

Behaviour:
- Reset (reset==0 at a clock edge):
  - pix_on=0, rgb=0, out_valid=0, blinking=0.
  - Latched position = (340,400). State = NORMAL. Frame and blink counters = 0.
  - Pipeline registers are cleared. Reset mid-frame drops in-flight pixels.
- Position latch: on a frame_start cycle, apx/apy are copied to apx_l/apy_l. Changes on apx/apy during the frame are ignored until the next frame_start.
- Pipeline stage 1 (registered):
  - dx = {1'b0,px} - ({1'b0,apx_l} - SPR_W/2) and dy = {1'b0,py} - ({1'b0,apy_l} - SPR_H/2), both 11-bit signed.
  - inside = pix_valid & (0 <= dx < SPR_W) & (0 <= dy < SPR_H).
  - Negative or overflowing dx/dy counts as outside. No wrap-around onto the opposite screen edge.
- Pipeline stage 2 (registered):
  - bit = rom[dy][dx].
  - pix_on = inside_d & bit & visible.
  - rgb = pix_on ? PLANE_RGB : 0.
  - out_valid = pix_valid delayed 2 cycles.
- Total latency from px/py to outputs: exactly 2 cycles. Throughput: 1 pixel per cycle, no stalls.
- State machine, advanced only on frame_start cycles except where noted:
  - NORMAL: visible=1. When hit=1 (any cycle): go to BLINK, blink_cnt=0, half_cnt=0.
  - BLINK:
    - On each frame_start, blink_cnt++. half_cnt counts 0..BLINK_HALF-1; when it wraps, visible toggles. The first half-period is invisible.
    - When blink_cnt reaches BLINK_FRAMES-1 on a frame_start, go to NORMAL with visible=1.
    - hit is ignored in BLINK (invulnerable), including a hit in the same cycle as the BLINK→NORMAL transition.
  - visible changes only at frame_start, so a frame is never partially blinked.
- blinking = (state==BLINK).
- hit and frame_start in the same cycle: position latches, and the state enters BLINK with blink_cnt=0. That frame_start is not counted.
- apx/apy values outside the legal range are still rendered by the same rules. Clipping comes from the dx/dy range checks.

Decomposition:
- Shared package (airplane_pkg):
  - screen constants H_ACTIVE=640, V_ACTIVE=480.
  - default position AP_X0=340, AP_Y0=400.
  - AP_X_MIN=20, AP_X_MAX=659.
  - state enum {NORMAL, BLINK}.
  - colour type (24-bit RGB).
- Sub-module airplane_rom:
  - Combinational 24x40-bit sprite bitmap (row = dy, column = dx).
  - Instantiated once; read in stage 2.
  - Same bitmap reused by future collision logic.

Test Plan:
- Reset then frame_start with apx=340, apy=400; scan px=320,py=388 with rom[0][0]=1 → pix_on=1 and rgb=24'hFFD000 exactly 2 cycles later. At px=319 → pix_on=0.
- Latch check: apx changes 340→345 mid-frame → sprite columns unchanged until the next frame_start. After it, left edge is at px=325.
- Clipping: apx=20 → coverage spans px=0..39, with no pixels near px=799. apy=10 → rows py=0..21 only, and dy wrap produces no pixels.
- Blink: hit pulse, then 96 frames → per frame, pix_on suppressed in frames 1-8, shown in 9-16, and so on. blinking=1 throughout; NORMAL after frame 96. A second hit at frame 50 has no effect.
- Simultaneous hit+frame_start → BLINK entered with blink_cnt=0 and the new position latched on the same edge.
- Mid-frame reset with pix_valid=1 → pix_on, out_valid and rgb are 0 on the next cycle and the following one; position is back to (340,400).

Source files
------------

// File: rtl/airplane_pkg.sv
// rtl/airplane_pkg.sv - shared screen constants, plane state and colour types
package airplane_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int AP_X0    = 340;
  localparam int AP_Y0    = 400;
  localparam int AP_X_MIN = 20;
  localparam int AP_X_MAX = 659;

  typedef enum logic {
    NORMAL = 1'b0,
    BLINK  = 1'b1
  } plane_state_t;

  typedef logic [23:0] rgb_t;

endpackage

// File: rtl/airplane_rom.sv
// rtl/airplane_rom.sv - 24x40 airplane sprite bitmap, bit [dx] of row [dy]
module airplane_rom (
  input  logic [5:0] col,
  input  logic [4:0] row,
  output logic       bit_on
);

  logic [39:0] row_bits;

  // Tail fin on columns 0-3, wing on columns 16-23, fuselage on rows 10-13.
  always_comb begin
    row_bits = 40'h00_0000_0000;
    case (row)
      5'd0, 5'd1, 5'd22, 5'd23:                          row_bits = 40'h00_0000_000F;
      5'd2, 5'd3, 5'd4, 5'd5, 5'd18, 5'd19, 5'd20, 5'd21: row_bits = 40'h00_00FF_000F;
      5'd6, 5'd7, 5'd8, 5'd9, 5'd14, 5'd15, 5'd16, 5'd17: row_bits = 40'h00_00FF_0000;
      5'd10, 5'd11, 5'd12, 5'd13:                        row_bits = 40'hFF_FFFF_FFFF;
      default:                                           row_bits = 40'h00_0000_0000;
    endcase
  end

  assign bit_on = (col < 6'd40) ? row_bits[col] : 1'b0;

endmodule

// File: rtl/airplane_render.sv
// rtl/airplane_render.sv - airplane sprite renderer: per-frame position latch,
// two-stage pixel pipeline and post-hit blink sequencer
module airplane_render
  import airplane_pkg::*;
#(
  parameter int   SPR_W        = 40,
  parameter int   SPR_H        = 24,
  parameter int   BLINK_FRAMES = 96,
  parameter int   BLINK_HALF   = 8,
  parameter rgb_t PLANE_RGB    = 24'hFFD000
) (
  input  logic       game_clk,
  input  logic       reset,
  input  logic       frame_start,
  input  logic [9:0] px,
  input  logic [9:0] py,
  input  logic       pix_valid,
  input  logic [9:0] apx,
  input  logic [9:0] apy,
  input  logic       hit,
  output logic       pix_on,
  output rgb_t       rgb,
  output logic       out_valid,
  output logic       blinking
);

  localparam int CW = $clog2(BLINK_FRAMES);
  localparam int HW = $clog2(BLINK_HALF);

  logic [9:0]    apx_l, apy_l;
  logic [10:0]   dx, dy;
  logic          s1_inside, s1_valid;
  logic [5:0]    s1_col;
  logic [4:0]    s1_row;
  logic          rom_bit, pix_hit;

  plane_state_t  state, state_n;
  logic [CW-1:0] blink_cnt, blink_cnt_n;
  logic [HW-1:0] half_cnt, half_cnt_n;
  logic          visible, visible_n;

  always_ff @(posedge game_clk) begin
    if (!reset) begin
      apx_l <= 10'(AP_X0);
      apy_l <= 10'(AP_Y0);
    end else if (frame_start) begin
      apx_l <= apx;
      apy_l <= apy;
    end
  end

  // Negative offsets show up with bit 10 set, so they fail the range check too.
  assign dx = {1'b0, px} - ({1'b0, apx_l} - 11'(SPR_W / 2));
  assign dy = {1'b0, py} - ({1'b0, apy_l} - 11'(SPR_H / 2));

  always_ff @(posedge game_clk) begin
    if (!reset) begin
      s1_inside <= 1'b0;
      s1_valid  <= 1'b0;
      s1_col    <= '0;
      s1_row    <= '0;
    end else begin
      s1_inside <= pix_valid && !dx[10] && (dx < 11'(SPR_W))
                             && !dy[10] && (dy < 11'(SPR_H));
      s1_valid  <= pix_valid;
      s1_col    <= dx[5:0];
      s1_row    <= dy[4:0];
    end
  end

  airplane_rom u_rom (
    .col    (s1_col),
    .row    (s1_row),
    .bit_on (rom_bit)
  );

  assign pix_hit = s1_inside & rom_bit & visible;

  always_ff @(posedge game_clk) begin
    if (!reset) begin
      pix_on    <= 1'b0;
      rgb       <= '0;
      out_valid <= 1'b0;
    end else begin
      pix_on    <= pix_hit;
      rgb       <= pix_hit ? PLANE_RGB : '0;
      out_valid <= s1_valid;
    end
  end

  always_ff @(posedge game_clk) begin
    if (!reset) begin
      state     <= NORMAL;
      blink_cnt <= '0;
      half_cnt  <= '0;
      visible   <= 1'b1;
    end else begin
      state     <= state_n;
      blink_cnt <= blink_cnt_n;
      half_cnt  <= half_cnt_n;
      visible   <= visible_n;
    end
  end

  // The frame in which the hit lands keeps its visibility; the first counted
  // frame opens the invisible half-period.
  always_comb begin
    state_n     = state;
    blink_cnt_n = blink_cnt;
    half_cnt_n  = half_cnt;
    visible_n   = visible;
    case (state)
      NORMAL: begin
        visible_n = 1'b1;
        if (hit) begin
          state_n     = BLINK;
          blink_cnt_n = '0;
          half_cnt_n  = '0;
        end
      end
      BLINK: begin
        if (frame_start) begin
          if (blink_cnt == CW'(BLINK_FRAMES - 1)) begin
            state_n     = NORMAL;
            blink_cnt_n = '0;
            half_cnt_n  = '0;
            visible_n   = 1'b1;
          end else begin
            blink_cnt_n = blink_cnt + 1'b1;
            if (blink_cnt == '0) begin
              half_cnt_n = '0;
              visible_n  = 1'b0;
            end else if (half_cnt == HW'(BLINK_HALF - 1)) begin
              half_cnt_n = '0;
              visible_n  = ~visible;
            end else begin
              half_cnt_n = half_cnt + 1'b1;
            end
          end
        end
      end
      default: state_n = NORMAL;
    endcase
  end

  always_comb begin
    blinking = (state == BLINK);
  end

endmodule

// File: tb/tb_airplane_render.sv
// tb/tb_airplane_render.sv - scoreboard bench for airplane_render
module tb_airplane_render;

  logic       game_clk = 1'b0;
  logic       reset, frame_start, pix_valid, hit;
  logic [9:0] px, py, apx, apy;
  logic       pix_on, out_valid, blinking;
  logic [23:0] rgb;

  typedef struct packed {
    logic        on;
    logic [23:0] rgb;
    logic        ov;
  } smp_t;

  smp_t exp_q[$];
  smp_t act_q[$];
  logic tracked = 1'b0, d1 = 1'b0, d2 = 1'b0;
  int   n_tests = 0, n_fail = 0;
  int   mx = 340, my = 400;
  logic mvis = 1'b1;

  always #5 game_clk = ~game_clk;

  airplane_render dut (
    .game_clk    (game_clk),
    .reset       (reset),
    .frame_start (frame_start),
    .px          (px),
    .py          (py),
    .pix_valid   (pix_valid),
    .apx         (apx),
    .apy         (apy),
    .hit         (hit),
    .pix_on      (pix_on),
    .rgb         (rgb),
    .out_valid   (out_valid),
    .blinking    (blinking)
  );

  // Outputs for a tracked pixel appear two clock edges after it is driven.
  always @(negedge game_clk) begin
    if (d2) act_q.push_back({pix_on, rgb, out_valid});
    d2 <= d1;
    d1 <= tracked;
  end

  function automatic logic exp_on(int x, int y, logic v);
    int ex, ey;
    ex = x - (mx - 20);
    ey = y - (my - 12);
    if (!v || !mvis || ex < 0 || ex >= 40 || ey < 0 || ey >= 24) return 1'b0;
    return (ey >= 10 && ey <= 13) || (ex >= 16 && ex <= 23 && ey >= 2 && ey <= 21)
        || (ex <= 3 && (ey <= 5 || ey >= 18));
  endfunction

  task automatic drive(int x, int y, logic v, logic drop);
    logic on;
    @(posedge game_clk); #1;
    px = 10'(x); py = 10'(y); pix_valid = v; tracked = 1'b1;
    on = drop ? 1'b0 : exp_on(x, y, v);
    exp_q.push_back({on, on ? 24'hFFD000 : 24'h000000, v & ~drop});
  endtask

  task automatic idle();
    @(posedge game_clk); #1;
    pix_valid = 1'b0; tracked = 1'b0;
    repeat (3) @(negedge game_clk);
  endtask

  task automatic frame(int ax, int ay, logic h);
    @(posedge game_clk); #1;
    apx = 10'(ax); apy = 10'(ay); frame_start = 1'b1; hit = h; pix_valid = 1'b0; tracked = 1'b0;
    @(posedge game_clk); #1;
    frame_start = 1'b0; hit = 1'b0;
    mx = ax; my = ay;
  endtask

  task automatic hit_pulse();
    @(posedge game_clk); #1; hit = 1'b1;
    @(posedge game_clk); #1; hit = 1'b0;
  endtask

  task automatic test_reset();
    smp_t e, a;
    repeat (3) @(posedge game_clk);
    @(negedge game_clk);
    n_tests++; if (pix_on !== 1'b0)    begin n_fail++; $display("FAIL reset pix_on: got %b expected 0", pix_on); end
    n_tests++; if (rgb !== 24'h0)      begin n_fail++; $display("FAIL reset rgb: got %h expected 000000", rgb); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset out_valid: got %b expected 0", out_valid); end
    n_tests++; if (blinking !== 1'b0)  begin n_fail++; $display("FAIL reset blinking: got %b expected 0", blinking); end
    @(posedge game_clk); #1; reset = 1'b1; pix_valid = 1'b0;
    mx = 340; my = 400; mvis = 1'b1;
    drive(320, 388, 1, 0); drive(319, 388, 1, 0); drive(359, 398, 1, 0); drive(360, 398, 1, 0);
    idle();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_tests++;
      if (act_q.size() == 0) begin n_fail++; $display("FAIL reset_default: no output, expected %h", e); end
      else begin
        a = act_q.pop_front();
        if (a !== e) begin n_fail++; $display("FAIL reset_default: got on=%b rgb=%h ov=%b expected on=%b rgb=%h ov=%b", a.on, a.rgb, a.ov, e.on, e.rgb, e.ov); end
      end
    end
  endtask

  task automatic test_render();
    smp_t e, a;
    frame(340, 400, 0);
    for (int x = 315; x <= 365; x++) drive(x, 388, 1, 0);
    for (int x = 318; x <= 362; x++) drive(x, 398, 1, 0);
    drive(320, 388, 0, 0);
    for (int y = 386; y <= 413; y++) drive(336, y, 1, 0);
    idle();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_tests++;
      if (act_q.size() == 0) begin n_fail++; $display("FAIL render: no output, expected %h", e); end
      else begin
        a = act_q.pop_front();
        if (a !== e) begin n_fail++; $display("FAIL render: got on=%b rgb=%h ov=%b expected on=%b rgb=%h ov=%b", a.on, a.rgb, a.ov, e.on, e.rgb, e.ov); end
      end
    end
  endtask

  task automatic test_latch();
    smp_t e, a;
    frame(340, 400, 0);
    apx = 10'd345;
    for (int x = 318; x <= 330; x++) drive(x, 388, 1, 0);
    idle();
    frame(345, 400, 0);
    for (int x = 318; x <= 330; x++) drive(x, 388, 1, 0);
    drive(364, 398, 1, 0); drive(365, 398, 1, 0);
    idle();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_tests++;
      if (act_q.size() == 0) begin n_fail++; $display("FAIL latch: no output, expected %h", e); end
      else begin
        a = act_q.pop_front();
        if (a !== e) begin n_fail++; $display("FAIL latch: got on=%b rgb=%h ov=%b expected on=%b rgb=%h ov=%b", a.on, a.rgb, a.ov, e.on, e.rgb, e.ov); end
      end
    end
  endtask

  task automatic test_clip();
    smp_t e, a;
    int xs[15] = '{0, 1, 3, 4, 16, 19, 23, 24, 38, 39, 40, 41, 639, 780, 799};
    int ys[10] = '{0, 1, 11, 21, 22, 23, 479, 480, 523, 524};
    int pos[3][2] = '{'{20, 10}, '{0, 10}, '{659, 470}};
    for (int p = 0; p < 3; p++) begin
      frame(pos[p][0], pos[p][1], 0);
      foreach (ys[j]) foreach (xs[i]) drive(xs[i], ys[j], 1, 0);
      idle();
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front(); n_tests++;
        if (act_q.size() == 0) begin n_fail++; $display("FAIL clip: no output, expected %h", e); end
        else begin
          a = act_q.pop_front();
          if (a !== e) begin n_fail++; $display("FAIL clip apx=%0d apy=%0d: got on=%b rgb=%h ov=%b expected on=%b rgb=%h ov=%b", mx, my, a.on, a.rgb, a.ov, e.on, e.rgb, e.ov); end
        end
      end
    end
  endtask

  task automatic test_blink();
    smp_t e, a;
    frame(340, 400, 0);
    mvis = 1'b1;
    n_tests++; if (blinking !== 1'b0) begin n_fail++; $display("FAIL blink_idle: got blinking=%b expected 0", blinking); end
    hit_pulse();
    n_tests++; if (blinking !== 1'b1) begin n_fail++; $display("FAIL blink_enter: got blinking=%b expected 1", blinking); end
    drive(320, 398, 1, 0); drive(339, 398, 1, 0);
    idle();
    for (int k = 1; k <= 100; k++) begin
      frame(340, 400, k == 96);
      if (k == 50) hit_pulse();
      mvis = (k >= 96) || (((k - 1) / 8) % 2 == 1);
      n_tests++;
      if (blinking !== 1'(k <= 95)) begin n_fail++; $display("FAIL blink frame %0d: got blinking=%b expected %b", k, blinking, k <= 95); end
      drive(320, 398, 1, 0); drive(358, 398, 1, 0);
      idle();
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front(); n_tests++;
        if (act_q.size() == 0) begin n_fail++; $display("FAIL blink frame %0d: no output, expected %h", k, e); end
        else begin
          a = act_q.pop_front();
          if (a !== e) begin n_fail++; $display("FAIL blink frame %0d: got on=%b rgb=%h ov=%b expected on=%b rgb=%h ov=%b", k, a.on, a.rgb, a.ov, e.on, e.rgb, e.ov); end
        end
      end
    end
  endtask

  task automatic test_hit_frame_start();
    smp_t e, a;
    frame(300, 300, 1);
    mvis = 1'b1;
    n_tests++; if (blinking !== 1'b1) begin n_fail++; $display("FAIL hit_fs enter: got blinking=%b expected 1", blinking); end
    drive(280, 288, 1, 0); drive(279, 288, 1, 0); drive(319, 298, 1, 0);
    idle();
    for (int k = 1; k <= 96; k++) begin
      frame(300, 300, 0);
      mvis = (k >= 96) || (((k - 1) / 8) % 2 == 1);
      n_tests++;
      if (blinking !== 1'(k <= 95)) begin n_fail++; $display("FAIL hit_fs frame %0d: got blinking=%b expected %b", k, blinking, k <= 95); end
      drive(280, 298, 1, 0);
      idle();
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_tests++;
      if (act_q.size() == 0) begin n_fail++; $display("FAIL hit_fs: no output, expected %h", e); end
      else begin
        a = act_q.pop_front();
        if (a !== e) begin n_fail++; $display("FAIL hit_fs: got on=%b rgb=%h ov=%b expected on=%b rgb=%h ov=%b", a.on, a.rgb, a.ov, e.on, e.rgb, e.ov); end
      end
    end
  endtask

  task automatic test_reset_midframe();
    smp_t e, a;
    frame(200, 200, 0);
    drive(180, 198, 1, 0);
    drive(181, 198, 1, 1);
    @(posedge game_clk); #1;
    reset = 1'b0; px = 10'd182; py = 10'd198; pix_valid = 1'b1; tracked = 1'b1;
    exp_q.push_back({1'b0, 24'h000000, 1'b0});
    @(posedge game_clk); #1;
    reset = 1'b1; pix_valid = 1'b0; tracked = 1'b0;
    mx = 340; my = 400; mvis = 1'b1;
    n_tests++; if (blinking !== 1'b0) begin n_fail++; $display("FAIL midreset blinking: got %b expected 0", blinking); end
    drive(320, 388, 1, 0); drive(319, 388, 1, 0); drive(200, 198, 1, 0);
    idle();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_tests++;
      if (act_q.size() == 0) begin n_fail++; $display("FAIL midreset: no output, expected %h", e); end
      else begin
        a = act_q.pop_front();
        if (a !== e) begin n_fail++; $display("FAIL midreset: got on=%b rgb=%h ov=%b expected on=%b rgb=%h ov=%b", a.on, a.rgb, a.ov, e.on, e.rgb, e.ov); end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; frame_start = 1'b0; hit = 1'b0; pix_valid = 1'b1;
    px = 10'd320; py = 10'd388; apx = 10'd340; apy = 10'd400;
    test_reset();
    test_render();
    test_latch();
    test_clip();
    test_blink();
    test_hit_frame_start();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
